// File: rtl/echo_pkg.sv
// Shared constants and state encoding for the echo datapath: controller, delay-line FIFO and MAC.
package echo_pkg;

  localparam int ECHO_ADDR_SIZE = 11;
  localparam int ECHO_DIV       = 4;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_FILL  = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  // Width of a counter that must hold 0..div-1 (at least one bit).
  function automatic int cnt_width(input int div);
    return (div <= 2) ? 1 : $clog2(div);
  endfunction

endpackage

// File: rtl/echo_delay_ctrl_if.sv
// Controller <-> FIFO/MAC/audio-side signal bundle; master is the controller.
interface echo_delay_ctrl_if #(
  parameter int ADDR_SIZE = echo_pkg::ECHO_ADDR_SIZE
);

  logic [ADDR_SIZE-1:0] delay;
  logic                 delay_load;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 sample_tick;
  logic                 wr_en;
  logic                 rd_en;
  logic                 fifo_clr;
  logic                 mix_en;
  logic                 err;

  modport master (
    input  delay, delay_load, fifo_full, fifo_empty,
    output sample_tick, wr_en, rd_en, fifo_clr, mix_en, err
  );

  modport slave (
    output delay, delay_load, fifo_full, fifo_empty,
    input  sample_tick, wr_en, rd_en, fifo_clr, mix_en, err
  );

endinterface

// File: rtl/sample_tick_gen.sv
// Sample-rate divider: tick is high for one clk every DIV clks, so the FIFO runs on clk with enables.
module sample_tick_gen
  import echo_pkg::*;
#(
  parameter int DIV = ECHO_DIV
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int            CW   = cnt_width(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] div_cnt_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_reg <= '0;
    end else if (div_cnt_reg == LAST) begin
      div_cnt_reg <= '0;
    end else begin
      div_cnt_reg <= div_cnt_reg + CW'(1);
    end
  end

  assign tick = (div_cnt_reg == LAST);

endmodule

// File: rtl/echo_delay_ctrl.sv
// Single-echo sequencer: clears and pre-fills the delay FIFO to delay_reg samples, then pairs
// read/write on every sample tick. Decisions are taken on the divider tick and land one clk later.
module echo_delay_ctrl
  import echo_pkg::*;
#(
  parameter int ADDR_SIZE = ECHO_ADDR_SIZE,
  parameter int DIV       = ECHO_DIV
) (
  input logic               clk,
  input logic               rst,
  echo_delay_ctrl_if.master bus
);

  logic tick;

  state_t               state_reg, state_next;
  logic [ADDR_SIZE-1:0] fill_cnt_reg, fill_cnt_next;
  logic [ADDR_SIZE-1:0] delay_reg, delay_next;
  logic                 err_reg, err_next;
  logic                 sample_tick_reg;
  logic                 wr_en_reg, wr_en_next;
  logic                 rd_en_reg, rd_en_next;
  logic                 fifo_clr_reg, fifo_clr_next;
  logic                 mix_en_reg, mix_en_next;

  sample_tick_gen #(.DIV(DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_CLEAR;
      fill_cnt_reg <= '0;
      delay_reg    <= ADDR_SIZE'(1);
      err_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      fill_cnt_reg <= fill_cnt_next;
      delay_reg    <= delay_next;
      err_reg      <= err_next;
    end
  end

  // delay_load overrides everything else, including a coincident tick or error.
  always_comb begin
    state_next    = state_reg;
    fill_cnt_next = fill_cnt_reg;
    delay_next    = delay_reg;
    err_next      = err_reg;
    if (bus.delay_load) begin
      delay_next = (bus.delay == '0) ? ADDR_SIZE'(1) : bus.delay;
      err_next   = 1'b0;
      state_next = ST_CLEAR;
    end else begin
      case (state_reg)
        ST_CLEAR: begin
          fill_cnt_next = '0;
          state_next    = ST_FILL;
        end
        ST_FILL: begin
          if (bus.fifo_full) begin
            err_next   = 1'b1;
            state_next = ST_CLEAR;
          end else if (tick) begin
            fill_cnt_next = fill_cnt_reg + ADDR_SIZE'(1);
            if (fill_cnt_next == delay_reg) begin
              state_next = ST_RUN;
            end
          end
        end
        ST_RUN: begin
          if (tick && bus.fifo_empty) begin
            err_next   = 1'b1;
            state_next = ST_CLEAR;
          end
        end
        default: state_next = ST_CLEAR;
      endcase
    end
  end

  // mix_en rises with the first paired read so the MAC never adds stale FIFO output.
  always_comb begin
    wr_en_next    = 1'b0;
    rd_en_next    = 1'b0;
    fifo_clr_next = 1'b0;
    mix_en_next   = 1'b0;
    if (!bus.delay_load) begin
      case (state_reg)
        ST_CLEAR: fifo_clr_next = 1'b1;
        ST_FILL:  wr_en_next    = tick && !bus.fifo_full;
        ST_RUN: begin
          if (tick) begin
            if (!bus.fifo_empty) begin
              wr_en_next  = 1'b1;
              rd_en_next  = 1'b1;
              mix_en_next = 1'b1;
            end
          end else begin
            mix_en_next = mix_en_reg;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sample_tick_reg <= 1'b0;
      wr_en_reg       <= 1'b0;
      rd_en_reg       <= 1'b0;
      fifo_clr_reg    <= 1'b0;
      mix_en_reg      <= 1'b0;
    end else begin
      sample_tick_reg <= tick;
      wr_en_reg       <= wr_en_next;
      rd_en_reg       <= rd_en_next;
      fifo_clr_reg    <= fifo_clr_next;
      mix_en_reg      <= mix_en_next;
    end
  end

  assign bus.sample_tick = sample_tick_reg;
  assign bus.wr_en       = wr_en_reg;
  assign bus.rd_en       = rd_en_reg;
  assign bus.fifo_clr    = fifo_clr_reg;
  assign bus.mix_en      = mix_en_reg;
  assign bus.err         = err_reg;

endmodule

// File: tb/tb_echo_delay_ctrl.sv
// Directed bench for echo_delay_ctrl (DIV=4, ADDR_SIZE=4) with a 16-deep occupancy model of the FIFO.
module tb_echo_delay_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic force_empty = 1'b0;
  logic force_full  = 1'b0;
  int   fifo_cnt    = 0;
  int   n_checks    = 0;
  int   n_fail      = 0;

  echo_delay_ctrl_if #(.ADDR_SIZE(4)) bus ();

  echo_delay_ctrl #(.ADDR_SIZE(4), .DIV(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  always #5 clk = ~clk;

  // FIFO occupancy model: clear wins, otherwise +write -read.
  always @(posedge clk) begin
    if (bus.fifo_clr) fifo_cnt <= 0;
    else fifo_cnt <= fifo_cnt + (bus.wr_en ? 1 : 0) - (bus.rd_en ? 1 : 0);
  end

  assign bus.fifo_empty = (fifo_cnt == 0) || force_empty;
  assign bus.fifo_full  = (fifo_cnt >= 16) || force_full;

  // {sample_tick, wr_en, rd_en, fifo_clr, mix_en, err}
  logic [5:0] outs;
  assign outs = {bus.sample_tick, bus.wr_en, bus.rd_en, bus.fifo_clr, bus.mix_en, bus.err};

  task automatic check_val(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      $display("chk %s ok (%0d)", tag, got);
    end
  endtask

  // Cycle-by-cycle output pattern expected right after reset release (delay_reg=1).
  task automatic check_startup(input string tag);
    logic [5:0] exp_seq [12];
    exp_seq = '{6'b000100, 6'b000000, 6'b000000, 6'b110000,
                6'b000000, 6'b000000, 6'b000000, 6'b111010,
                6'b000010, 6'b000010, 6'b000010, 6'b111010};
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      check_val($sformatf("%s_k%0d", tag, k), int'(outs), int'(exp_seq[k]));
      if (k == 8) check_val({tag, "_cnt"}, fifo_cnt, 1);
    end
  endtask

  task automatic load_delay(input int d, input string tag);
    bus.delay      = 4'(d);
    bus.delay_load = 1'b1;
    @(negedge clk);
    bus.delay_load = 1'b0;
    check_val({tag, "_gate"}, int'(outs & 6'b011011), 0);
  endtask

  task automatic measure_fill(output int clr_n, output int fill_n, output bit found);
    clr_n  = 0;
    fill_n = 0;
    found  = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (bus.fifo_clr) clr_n++;
      if (bus.sample_tick && bus.wr_en && bus.rd_en) found = 1'b1;
      else if (bus.sample_tick && bus.wr_en) fill_n++;
    end
  endtask

  task automatic wait_tick(input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 12 && !seen; i++) begin
      @(negedge clk);
      seen = bus.sample_tick;
    end
    check_val(tag, int'(seen), 1);
  endtask

  initial begin
    int  clr_n, fill_n;
    bit  found;
    bus.delay      = '0;
    bus.delay_load = 1'b0;

    // 1: reset state, then auto CLEAR -> one fill tick -> RUN
    repeat (3) @(negedge clk);
    check_val("reset_outs", int'(outs), 0);
    rst = 1'b0;
    check_startup("t1");

    // 2: delay=5
    load_delay(5, "t2");
    measure_fill(clr_n, fill_n, found);
    check_val("t2_found", int'(found), 1);
    check_val("t2_clr", clr_n, 1);
    check_val("t2_fill", fill_n, 5);
    check_val("t2_cnt", fifo_cnt, 5);
    repeat (4) @(negedge clk);
    check_val("t2_pair2", int'(outs), 6'b111010);
    check_val("t2_cnt2", fifo_cnt, 5);

    // 3: delay=0 behaves as 1
    load_delay(0, "t3");
    measure_fill(clr_n, fill_n, found);
    check_val("t3_found", int'(found), 1);
    check_val("t3_fill", fill_n, 1);

    // 4: empty on a RUN tick
    wait_tick("t4_tick");
    repeat (3) @(negedge clk);
    force_empty = 1'b1;
    @(negedge clk);
    force_empty = 1'b0;
    check_val("t4_err_tick", int'(outs), 6'b100001);
    @(negedge clk);
    check_val("t4_clr", int'(outs), 6'b000101);
    measure_fill(clr_n, fill_n, found);
    check_val("t4_found", int'(found), 1);
    check_val("t4_fill", fill_n, 1);
    check_val("t4_sticky", int'(outs), 6'b111011);

    // 5: delay_load on the RUN tick decision cycle
    wait_tick("t5_tick");
    repeat (3) @(negedge clk);
    bus.delay      = 4'd2;
    bus.delay_load = 1'b1;
    @(negedge clk);
    bus.delay_load = 1'b0;
    check_val("t5_load_tick", int'(outs), 6'b100000);
    @(negedge clk);
    check_val("t5_clr", int'(outs), 6'b000100);
    measure_fill(clr_n, fill_n, found);
    check_val("t5_found", int'(found), 1);
    check_val("t5_fill", fill_n, 2);

    // 7: full during FILL
    load_delay(3, "t7");
    @(negedge clk);
    check_val("t7_clr1", int'(outs[2]), 1);
    force_full = 1'b1;
    @(negedge clk);
    force_full = 1'b0;
    check_val("t7_err", int'(outs & 6'b010001), 6'b000001);
    @(negedge clk);
    check_val("t7_clr2", int'(outs[2]), 1);

    // 6: max delay, then reset mid-FILL
    load_delay(15, "t6");
    measure_fill(clr_n, fill_n, found);
    check_val("t6_found", int'(found), 1);
    check_val("t6_fill", fill_n, 15);
    check_val("t6_err", int'(outs[0]), 0);
    check_val("t6_cnt", fifo_cnt, 15);
    load_delay(15, "t6b");
    repeat (20) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_val("t6_rst1", int'(outs), 0);
    @(negedge clk);
    check_val("t6_rst2", int'(outs), 0);
    rst = 1'b0;
    check_startup("t6r");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
